led_share_arbiter: RTL and testbench
====================================

Name: led_share_arbiter

Overview:
- Shares the single on-board RGB LED between N_REQ status requesters.
- Each requester presents a 3-bit {R,G,B} colour and a request line.
- The arbiter grants the LED round-robin and shows the winner's colour for a fixed, non-preemptive dwell time. The LED is then released for re-arbitration.
- Sits between status sources (colour cycler, error flags, heartbeat) and the top-level RGB_R/RGB_G/RGB_B pins.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- DWELL_CYCLES, 2_000_000, clk cycles a granted colour is shown (1/6 s at 12 MHz).
- CNT_W, 21, dwell counter width; must satisfy 2**CNT_W >= DWELL_CYCLES.

Ports:
- clk  input  1  system clock, 12 MHz.
- rst  input  1  asynchronous, active-high reset.
- req  input  N_REQ  request per requester; level-sensitive.
- color  input  3*N_REQ  requester i colour at bits [3i+2:3i], order {R,G,B}.
- grant  output  N_REQ  one-hot grant; all zero when idle.
- busy  output  1  high while a colour is being shown.
- RGB_R  output  1  LED red drive, active-high.
- RGB_G  output  1  LED green drive, active-high.
- RGB_B  output  1  LED blue drive, active-high.

Behaviour:
- Reset (async, active-high) forces:
  - state=IDLE, grant=0, busy=0, RGB=000, dwell counter=0, colour latch=000.
  - Round-robin pointer last=N_REQ-1, so req[0] has first priority after reset.
- FSM has two states, IDLE and SHOW. All outputs derive from registers; no combinational path from req or color to outputs.
- IDLE:
  - LED off, grant=0, busy=0.
  - On any clk edge with req!=0, the winner i is the first set bit searching last+1, last+2, ... with wrap modulo N_REQ.
  - On that edge: grant<=onehot(i), colour latch<=color[3i+2:3i], counter<=0, last<=i, state<=SHOW.
  - Latency: req sampled high at edge k gives grant/RGB valid after edge k (one cycle).
- SHOW:
  - RGB = colour latch, busy=1, grant held, counter increments each cycle.
  - At the edge where counter==DWELL_CYCLES-1: state<=IDLE, grant<=0, counter<=0. SHOW therefore lasts exactly DWELL_CYCLES cycles.
- Non-preemptive: dropping req[i] or changing color mid-SHOW has no effect. The dwell completes with the latched colour.
- Every SHOW is followed by at least one IDLE cycle with the LED off. Back-to-back grants are therefore separated by exactly one dark cycle.
- Fairness: with all requests held high, grants rotate 0,1,...,N_REQ-1,0,... Worst-case wait is (N_REQ-1)*(DWELL_CYCLES+1)+1 cycles.
- Colour 000 is a valid request. The LED stays dark, but the grant and dwell still run.
- Counter wrap: the counter never exceeds DWELL_CYCLES-1. There is no free-running wrap.
- Reset mid-SHOW: everything returns to reset values immediately (async). The pointer reset means req[0] wins next.
- Requests are assumed synchronous to clk; no internal synchroniser.

Optional Feature:
- Macro: LED_SHARE_PWM_DIM_EN.
- With the macro defined:
  - Adds input port brightness, 4 bits, and a free-running 4-bit PWM counter pwm_cnt (reset 0).
  - During SHOW, each RGB bit = latched bit AND (pwm_cnt < brightness).
  - brightness=0 gives always off; brightness=15 gives 15/16 duty. brightness is sampled live, not latched.
  - grant, busy and dwell timing are unchanged.
- Without the macro: no brightness port, no PWM counter, full-on drive.

Test Plan (DWELL_CYCLES=8, N_REQ=4 unless noted):
- Reset: rst=1 with req=4'b1111 → grant=0, busy=0, RGB=000. rst released → next edge grant=4'b0001.
- Single request: req=4'b0100, color[8:6]=3'b110 → next edge grant=4'b0100, RGB=110 for exactly 8 cycles, then one cycle RGB=000, busy=0, then re-grant 4'b0100.
- Round-robin: req=4'b1111 held for 40 cycles → grant sequence 0001,0010,0100,1000,0001. Each grant lasts 8 cycles, separated by a 1-cycle gap.
- Non-preemption: grant=4'b0010 at SHOW cycle 3, then drop req[1] and change color[5:3] → RGB keeps the latched value through cycle 8, grant stays 4'b0010.
- Async reset mid-SHOW: assert rst at SHOW cycle 4 between edges → outputs go to 0 immediately without a clock edge. After release with req=4'b1000, next edge grant=4'b1000.
- LED_SHARE_PWM_DIM_EN: brightness=4, color=111 granted → over 16 consecutive SHOW cycles each RGB bit is high exactly 4 cycles. With brightness=0 the LED stays 000 while busy=1.

Source files
------------

// File: rtl/led_share_arbiter.sv
// Round-robin arbiter sharing one RGB LED between N_REQ status sources; each grant
// shows the winner's latched colour for DWELL_CYCLES clocks. Optional LED_SHARE_PWM_DIM_EN adds PWM dimming.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | LED dark, no grant; arbitrate on any pending request
// SHOW  | winner's latched colour driven for DWELL_CYCLES cycles
module led_share_arbiter #(
  parameter int N_REQ        = 4,
  parameter int DWELL_CYCLES = 2_000_000,
  parameter int CNT_W        = 21
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_REQ-1:0]     req,
  input  logic [3*N_REQ-1:0]   color,
`ifdef LED_SHARE_PWM_DIM_EN
  input  logic [3:0]           brightness,
`endif
  output logic [N_REQ-1:0]     grant,
  output logic                 busy,
  output logic                 RGB_R,
  output logic                 RGB_G,
  output logic                 RGB_B
);

  localparam int                IDX_W    = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DWELL_CYCLES - 1);
  localparam logic [IDX_W-1:0]  LAST_RST = IDX_W'(N_REQ - 1);

  typedef enum logic {
    IDLE = 1'b0,
    SHOW = 1'b1
  } state_t;

  state_t             state, state_nxt;
  logic [N_REQ-1:0]   grant_nxt;
  logic [2:0]         latch, latch_nxt;
  logic [CNT_W-1:0]   cnt, cnt_nxt;
  logic [IDX_W-1:0]   last, last_nxt;
  logic               win_found;
  logic [IDX_W-1:0]   win_idx;
  logic [IDX_W-1:0]   cand_idx;
  int                 cand;
  logic [2:0]         color_arr [N_REQ];
  logic [2:0]         rgb_on;

  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_col
    assign color_arr[gi] = color[3*gi +: 3];
  end

  // Search starts one past the previous winner so every source gets a turn.
  always_comb begin
    win_found = 1'b0;
    win_idx   = last;
    cand      = 0;
    cand_idx  = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      cand     = (int'(last) + k) % N_REQ;
      cand_idx = IDX_W'(cand);
      if (!win_found && req[cand_idx]) begin
        win_found = 1'b1;
        win_idx   = cand_idx;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    grant_nxt = grant;
    latch_nxt = latch;
    cnt_nxt   = cnt;
    last_nxt  = last;
    case (state)
      IDLE: begin
        if (win_found) begin
          state_nxt          = SHOW;
          grant_nxt          = '0;
          grant_nxt[win_idx] = 1'b1;
          latch_nxt          = color_arr[win_idx];
          cnt_nxt            = '0;
          last_nxt           = win_idx;
        end
      end
      SHOW: begin
        if (cnt == CNT_LAST) begin
          state_nxt = IDLE;
          grant_nxt = '0;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      default: begin
        state_nxt = IDLE;
        grant_nxt = '0;
        cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      grant <= '0;
      latch <= 3'b000;
      cnt   <= '0;
      last  <= LAST_RST;
    end else begin
      state <= state_nxt;
      grant <= grant_nxt;
      latch <= latch_nxt;
      cnt   <= cnt_nxt;
      last  <= last_nxt;
    end
  end

  assign busy   = (state == SHOW);
  assign rgb_on = busy ? latch : 3'b000;

`ifdef LED_SHARE_PWM_DIM_EN
  logic [3:0] pwm_cnt;
  logic       pwm_on;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) pwm_cnt <= 4'd0;
    else     pwm_cnt <= pwm_cnt + 4'd1;
  end

  // Brightness is applied live so dimming can change mid-dwell.
  assign pwm_on = (pwm_cnt < brightness);
  assign {RGB_R, RGB_G, RGB_B} = rgb_on & {3{pwm_on}};
`else
  assign {RGB_R, RGB_G, RGB_B} = rgb_on;
`endif

endmodule

// File: tb/tb_led_share_arbiter.sv
// Bench for led_share_arbiter: a grant/dwell model checked every cycle plus directed literal checks.
module tb_led_share_arbiter;
  localparam int N  = 4;
  localparam int DW = 8;
  localparam int CW = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  req = 4'b0000;
  logic [11:0] color = 12'h000;
  logic [3:0]  grant;
  logic        busy, RGB_R, RGB_G, RGB_B;
  logic [2:0]  rgb;
`ifdef LED_SHARE_PWM_DIM_EN
  logic [3:0]  brightness = 4'd15;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  bit check_en = 1'b0;

  led_share_arbiter #(.N_REQ(N), .DWELL_CYCLES(DW), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .req(req), .color(color),
`ifdef LED_SHARE_PWM_DIM_EN
    .brightness(brightness),
`endif
    .grant(grant), .busy(busy), .RGB_R(RGB_R), .RGB_G(RGB_G), .RGB_B(RGB_B)
  );

  assign rgb = {RGB_R, RGB_G, RGB_B};

  always #5 clk = ~clk;

  // Model: owner index (-1 idle), remaining dwell cycles, latched colour, pointer.
  int         m_owner = -1;
  int         m_left  = 0;
  int         m_last  = N - 1;
  logic [2:0] m_color = 3'b000;
  int         m_pwm   = 0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_owner = -1;
      m_left  = 0;
      m_last  = N - 1;
      m_color = 3'b000;
      m_pwm   = 0;
    end else begin
      m_pwm = (m_pwm + 1) % 16;
      if (m_owner < 0) begin
        for (int k = 1; k <= N; k++) begin
          int j;
          j = (m_last + k) % N;
          if (m_owner < 0 && req[j]) begin
            m_owner = j;
            m_color = color[3*j +: 3];
            m_left  = DW;
            m_last  = j;
          end
        end
      end else begin
        m_left = m_left - 1;
        if (m_left == 0) m_owner = -1;
      end
    end
  end

  function automatic logic [2:0] lit_rgb(input logic [2:0] x);
`ifdef LED_SHARE_PWM_DIM_EN
    return (m_pwm < int'(brightness)) ? x : 3'b000;
`else
    return x;
`endif
  endfunction

  function automatic logic [2:0] exp_rgb();
    return (m_owner < 0) ? 3'b000 : lit_rgb(m_color);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (check_en) begin
      chk("model_grant", 32'(grant), (m_owner < 0) ? 32'd0 : (32'd1 << m_owner));
      chk("model_busy",  32'(busy),  (m_owner < 0) ? 32'd0 : 32'd1);
      chk("model_rgb",   32'(rgb),   32'(exp_rgb()));
    end
  end

  task automatic wait_idle();
    int w;
    w = 0;
    @(negedge clk);
    while (busy && w < 20) begin
      @(negedge clk);
      w++;
    end
    chk("idle_wait", 32'(busy), 32'd0);
  endtask

  logic [3:0] exp_vals [9] = '{4'b0001, 4'b0000, 4'b0010, 4'b0000, 4'b0100,
                               4'b0000, 4'b1000, 4'b0000, 4'b0001};
  int         exp_lens [9] = '{8, 1, 8, 1, 8, 1, 8, 1, 8};

  initial begin
    logic [3:0] run_vals[$];
    int         run_lens[$];
    logic [3:0] prev;
    int         runlen;

    check_en = 1'b1;
    rst   = 1'b1;
    req   = 4'b1111;
    color = {3'b001, 3'b010, 3'b011, 3'b100};
    repeat (3) @(negedge clk);
    chk("reset_grant", 32'(grant), 32'd0);
    chk("reset_busy",  32'(busy),  32'd0);
    chk("reset_rgb",   32'(rgb),   32'd0);

    // Round-robin with all requests held.
    rst = 1'b0;
    @(negedge clk);
    chk("rr_first_grant", 32'(grant), 32'b0001);
    prev   = grant;
    runlen = 1;
    for (int c = 1; c < 44; c++) begin
      @(negedge clk);
      if (grant == prev) runlen++;
      else begin
        run_vals.push_back(prev);
        run_lens.push_back(runlen);
        prev   = grant;
        runlen = 1;
      end
    end
    run_vals.push_back(prev);
    run_lens.push_back(runlen);
    chk("rr_run_count", 32'(run_vals.size()), 32'd9);
    for (int r = 0; r < 9 && r < run_vals.size(); r++) begin
      chk("rr_run_value", 32'(run_vals[r]), 32'(exp_vals[r]));
      chk("rr_run_len",   32'(run_lens[r]), 32'(exp_lens[r]));
    end

    // Single requester: 8 lit cycles, one dark cycle, re-grant.
    req = 4'b0000;
    wait_idle();
    req = 4'b0100;
    color[8:6] = 3'b110;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      chk("single_grant", 32'(grant), 32'b0100);
      chk("single_rgb",   32'(rgb),   32'(lit_rgb(3'b110)));
    end
    @(negedge clk);
    chk("single_gap_busy",  32'(busy),  32'd0);
    chk("single_gap_rgb",   32'(rgb),   32'd0);
    chk("single_gap_grant", 32'(grant), 32'd0);
    @(negedge clk);
    chk("single_regrant", 32'(grant), 32'b0100);

    // Non-preemption: drop request and change colour at SHOW cycle 3.
    req = 4'b0000;
    wait_idle();
    req = 4'b0010;
    color[5:3] = 3'b011;
    repeat (3) @(negedge clk);
    chk("np_grant_c3", 32'(grant), 32'b0010);
    req = 4'b0000;
    color[5:3] = 3'b100;
    for (int c = 4; c <= 8; c++) begin
      @(negedge clk);
      chk("np_grant", 32'(grant), 32'b0010);
      chk("np_rgb",   32'(rgb),   32'(lit_rgb(3'b011)));
    end
    @(negedge clk);
    chk("np_end_grant", 32'(grant), 32'd0);
    chk("np_end_busy",  32'(busy),  32'd0);

    // Colour 000 still runs a grant.
    wait_idle();
    req = 4'b0100;
    color[8:6] = 3'b000;
    @(negedge clk);
    chk("black_grant", 32'(grant), 32'b0100);
    chk("black_busy",  32'(busy),  32'd1);
    chk("black_rgb",   32'(rgb),   32'd0);

    // Async reset mid-SHOW.
    req = 4'b0000;
    wait_idle();
    req = 4'b0001;
    color[2:0] = 3'b101;
    repeat (4) @(negedge clk);
    chk("ar_pre_grant", 32'(grant), 32'b0001);
    chk("ar_pre_rgb",   32'(rgb),   32'(lit_rgb(3'b101)));
    #1 rst = 1'b1;
    #1;
    chk("ar_grant", 32'(grant), 32'd0);
    chk("ar_busy",  32'(busy),  32'd0);
    chk("ar_rgb",   32'(rgb),   32'd0);
    req = 4'b1000;
    #1 rst = 1'b0;
    @(negedge clk);
    chk("ar_regrant", 32'(grant), 32'b1000);

`ifdef LED_SHARE_PWM_DIM_EN
    req = 4'b0000;
    wait_idle();
    brightness = 4'd0;
    req = 4'b0001;
    color[2:0] = 3'b111;
    repeat (3) begin
      @(negedge clk);
      chk("pwm_off_busy", 32'(busy), 32'd1);
      chk("pwm_off_rgb",  32'(rgb),  32'd0);
    end
    brightness = 4'd15;
`endif

    req = 4'b0000;
    repeat (12) @(negedge clk);
    check_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
